// File: rtl/store_buffer_writer_if.sv
// Sram-like data bus between the store buffer (master) and the data memory (slave).
interface store_buffer_writer_if #(
  parameter int WIDTH = 32
);
  logic             data_req;
  logic             data_wr;
  logic [1:0]       data_size;
  logic [WIDTH-1:0] data_addr;
  logic [WIDTH-1:0] data_wdata;
  logic [3:0]       data_wstrb;
  logic             data_addr_ok;
  logic             data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/store_buffer_writer.sv
// MEM-stage store path: formats stores, queues them in a FIFO and drains them over the data bus.
// Optional macro SWLR_STORE_EN enables SWL/SWR (types 011/100) formatting.
module store_buffer_writer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             store_valid_in,
  input  logic [WIDTH-1:0] store_addr_in,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic [2:0]       store_type_in,
  input  logic [3:0]       exception_in,
  input  logic             flush,
  output logic             store_ready_out,
  output logic [3:0]       exception_out,
  output logic             buf_empty,
  store_buffer_writer_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  localparam logic [2:0] T_SB = 3'b000;
  localparam logic [2:0] T_SH = 3'b001;
  localparam logic [2:0] T_SW = 3'b010;
`ifdef SWLR_STORE_EN
  localparam logic [2:0] T_SWL = 3'b011;
  localparam logic [2:0] T_SWR = 3'b100;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [PW:0]      count_q, count_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic             data_req_q, data_req_d;
  logic             data_wr_q, data_wr_d;
  logic [1:0]       data_size_q, data_size_d;
  logic [WIDTH-1:0] data_addr_q, data_addr_d;
  logic [WIDTH-1:0] data_wdata_q, data_wdata_d;
  logic [3:0]       data_wstrb_q, data_wstrb_d;

  logic [WIDTH-1:0] mem_addr_q  [DEPTH];
  logic [WIDTH-1:0] mem_wdata_q [DEPTH];
  logic [3:0]       mem_wstrb_q [DEPTH];
  logic [1:0]       mem_size_q  [DEPTH];

  logic             misaligned;
  logic             type_ok;
  logic             push;
  logic             pop;
  logic [1:0]       k;
  logic [WIDTH-1:0] fmt_addr;
  logic [WIDTH-1:0] fmt_wdata;
  logic [3:0]       fmt_wstrb;
  logic [1:0]       fmt_size;

  assign k = store_addr_in[1:0];

  always_comb begin
    misaligned = 1'b0;
    type_ok    = 1'b0;
    fmt_addr   = store_addr_in;
    fmt_wdata  = store_data_in;
    fmt_wstrb  = 4'b0000;
    fmt_size   = 2'd0;
    case (store_type_in)
      T_SB: begin
        type_ok   = 1'b1;
        fmt_wdata = {(WIDTH/8){store_data_in[7:0]}};
        fmt_wstrb = 4'b0001 << k;
        fmt_size  = 2'd0;
      end
      T_SH: begin
        type_ok    = 1'b1;
        misaligned = k[0];
        fmt_wdata  = {(WIDTH/16){store_data_in[15:0]}};
        fmt_wstrb  = k[1] ? 4'b1100 : 4'b0011;
        fmt_size   = 2'd1;
      end
      T_SW: begin
        type_ok    = 1'b1;
        misaligned = (k != 2'd0);
        fmt_wstrb  = 4'b1111;
        fmt_size   = 2'd2;
      end
`ifdef SWLR_STORE_EN
      // Unaligned word halves: both target the aligned word containing the address.
      T_SWL: begin
        type_ok   = 1'b1;
        fmt_addr  = {store_addr_in[WIDTH-1:2], 2'b00};
        fmt_wdata = store_data_in >> {2'd3 - k, 3'b000};
        fmt_wstrb = 4'b1111 >> (2'd3 - k);
        fmt_size  = 2'd2;
      end
      T_SWR: begin
        type_ok   = 1'b1;
        fmt_addr  = {store_addr_in[WIDTH-1:2], 2'b00};
        fmt_wdata = store_data_in << {k, 3'b000};
        fmt_wstrb = 4'b1111 << k;
        fmt_size  = 2'd2;
      end
`endif
      default: ;
    endcase
  end

  assign exception_out   = misaligned ? 4'd5 : exception_in;
  assign store_ready_out = (count_q != FULL_COUNT);
  assign buf_empty       = (count_q == '0) && (state_q == S_IDLE);
  assign push = store_valid_in & store_ready_out & ~flush & (exception_in == 4'd0)
              & ~misaligned & type_ok;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[tail_q]  <= fmt_addr;
      mem_wdata_q[tail_q] <= fmt_wdata;
      mem_wstrb_q[tail_q] <= fmt_wstrb;
      mem_size_q[tail_q]  <= fmt_size;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      data_size_q  <= 2'd0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      data_wstrb_q <= 4'b0000;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      data_req_q   <= data_req_d;
      data_wr_q    <= data_wr_d;
      data_size_q  <= data_size_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      data_wstrb_q <= data_wstrb_d;
    end
  end

  // The head entry stays counted until data_ok so a full buffer never overruns.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_REQ;
      S_REQ: begin
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            pop     = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.data_data_ok) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
  end

  always_comb begin
    data_req_d   = data_req_q;
    data_wr_d    = data_wr_q;
    data_size_d  = data_size_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;
    data_wstrb_d = data_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          data_req_d   = 1'b1;
          data_wr_d    = 1'b1;
          data_size_d  = mem_size_q[head_q];
          data_addr_d  = mem_addr_q[head_q];
          data_wdata_d = mem_wdata_q[head_q];
          data_wstrb_d = mem_wstrb_q[head_q];
        end
      end
      S_REQ: begin
        if (bus.data_addr_ok) begin
          data_req_d = 1'b0;
          data_wr_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.data_req   = data_req_q;
  assign bus.data_wr    = data_wr_q;
  assign bus.data_size  = data_size_q;
  assign bus.data_addr  = data_addr_q;
  assign bus.data_wdata = data_wdata_q;
  assign bus.data_wstrb = data_wstrb_q;

endmodule

// File: doc/store_buffer_writer.md
Name: store_buffer_writer

Overview:
- MEM-stage store path. Write-side counterpart of the WB load-data extractor.
- Takes store requests (address, register data, store type) and produces lane-replicated write data, byte strobes and size, and flags misaligned stores as address-error exceptions.
- Queues accepted stores in a small FIFO and drains them one at a time over the sram-like data bus (req / addr_ok / data_ok).

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- WIDTH, 32, address and data width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- store_valid_in  in  1  MEM stage presents a store.
- store_addr_in  in  WIDTH  byte address (ALU result).
- store_data_in  in  WIDTH  rt register value.
- store_type_in  in  3  000 SB, 001 SH, 010 SW, 011 SWL, 100 SWR.
- exception_in  in  4  exception code already carried by the instruction.
- flush  in  1  kill the current MEM instruction.
- store_ready_out  out  1  FIFO can accept this cycle.
- exception_out  out  4  exception code forwarded to WB.
- buf_empty  out  1  no queued or in-flight store.
- data_req  out  1  bus request.
- data_wr  out  1  always 1 while data_req.
- data_size  out  2  0 byte, 1 half, 2 word.
- data_addr  out  WIDTH  bus address.
- data_wdata  out  WIDTH  lane-positioned write data.
- data_wstrb  out  4  byte enables; authoritative over data_size.
- data_addr_ok  in  1  slave accepted the address.
- data_data_ok  in  1  slave completed the write.

Behaviour:
- Misalignment (combinational): SH with addr[0]=1, or SW with addr[1:0]!=0, gives exception_out=4'd5 (AdES). Otherwise exception_out=exception_in.
- push = store_valid_in & store_ready_out & ~flush & exception_in==0 & ~misaligned. On push the formatted entry {addr, wdata, wstrb, size} is written at the tail; count increments.
- store_ready_out = (count != DEPTH), from registered count. No push while full, even if a pop happens in the same cycle.
- Formatting, with k=addr[1:0]:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<k, size 0, addr unchanged.
  - SH: wdata={2{d[15:0]}}, wstrb=0011 (k=0) or 1100 (k=2), size 1.
  - SW: wdata=d, wstrb=1111, size 2.
  - SWL: wdata=d>>(8*(3-k)), wstrb=(1<<(k+1))-1, addr={addr[31:2],00}, size 2.
  - SWR: wdata=d<<(8*k), wstrb=4'b1111<<k, addr={addr[31:2],00}, size 2.
- Drain FSM, registered bus outputs, at most one outstanding write:
  - IDLE: if count!=0, load head fields, set data_req=1, go to REQ.
  - REQ: hold data_req and all fields stable until data_addr_ok. On addr_ok, clear data_req and go to WAIT. If data_data_ok is also high that cycle, pop immediately and go to IDLE.
  - WAIT: on data_data_ok, pop (head++, count--) and go to IDLE.
- The head entry stays counted until data_ok. Push and pop in the same cycle leave count unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- flush blocks only the current push. Entries already queued always drain; committed stores are never discarded.
- buf_empty = (count==0) & (state==IDLE). The pipeline stalls younger loads on ~buf_empty.
- Reset (asynchronous, any time, including mid-transaction):
  - count, pointers and state go to 0 / IDLE.
  - data_req, data_wr, data_size, data_addr, data_wdata and data_wstrb go to 0.
  - The in-flight bus transaction is abandoned; the slave is reset together with this block.
- exception_out has no reset value (combinational).

Optional Feature:
- Macro SWLR_STORE_EN.
- Defined: types 011/100 are formatted as SWL/SWR as above, and never raise AdES.
- Undefined: types 011/100 are not pushed, raise no exception, and exception_out=exception_in. The SWL/SWR shifters are not synthesized.

Test Plan:
1. SB, addr 0x1003, data 0x000000AB -> one bus write: addr 0x1003, size 0, wstrb 1000, wdata 0xABABABAB; buf_empty returns to 1 after data_ok.
2. SH, addr 0x2001 -> exception_out=5, no push, count stays 0. Then SW, addr 0x2004, with exception_in=3 -> no push, exception_out=3.
3. DEPTH+1 back-to-back SW with the slave holding addr_ok=0 -> store_ready_out falls after the 4th push and the 5th is held. Release addr_ok/data_ok -> writes appear in push order.
4. addr_ok and data_ok asserted in the same cycle as the REQ -> single-cycle pop. A push in that same cycle leaves count unchanged.
5. SWL, addr 0x3001, data 0x11223344 -> wdata 0x00001122, wstrb 0011, addr 0x3000. SWR, addr 0x3001 -> wdata 0x22334400, wstrb 1110. (Both with SWLR_STORE_EN defined; with it undefined -> no bus traffic.)
6. Assert resetn low while in WAIT with 2 entries queued -> data_req=0, buf_empty=1 immediately. No write issues after release until a new push.
